// File: rtl/cci_mpf_prim_lfsr_pkg.sv
// Shared LFSR helpers: Galois feedback tap table, single-step and rotate functions.
// All arithmetic is done on LFSR_MAX_WIDTH-bit words and trimmed by the caller.
package cci_mpf_prim_lfsr_pkg;

   localparam int LFSR_MAX_WIDTH = 32;

   typedef logic [LFSR_MAX_WIDTH-1:0] lfsr_word_t;

   function automatic lfsr_word_t lfsr_width_mask(input int width);
      if (width >= LFSR_MAX_WIDTH) begin
         return '1;
      end
      return (lfsr_word_t'(1) << width) - lfsr_word_t'(1);
   endfunction

   // Zero means "no table entry" and is rejected at elaboration by the user.
   function automatic lfsr_word_t lfsr_taps(input int width);
      case (width)
         4:       return lfsr_word_t'(32'h1);
         12:      return lfsr_word_t'(32'h029);
         32:      return lfsr_word_t'(32'h57);
         default: return '0;
      endcase
   endfunction

   function automatic lfsr_word_t lfsr_step(input lfsr_word_t value,
                                            input lfsr_word_t mask,
                                            input int         width);
      lfsr_word_t rot;
      rot = ((value >> 1) | (lfsr_word_t'(value[0]) << (width - 1))) & lfsr_width_mask(width);
      if (value[0]) begin
         rot = rot ^ mask;
      end
      return rot;
   endfunction

   function automatic lfsr_word_t lfsr_rotl(input lfsr_word_t value,
                                            input int         amount,
                                            input int         width);
      lfsr_word_t r;
      r = value & lfsr_width_mask(width);
      for (int i = 0; i < amount; i++) begin
         r = ((r << 1) | (r >> (width - 1))) & lfsr_width_mask(width);
      end
      return r;
   endfunction

endpackage

// File: rtl/cci_mpf_prim_lfsr_lane.sv
// One LFSR lane: state, seed, period pulse, sticky zero-seed flag and optional step counter.
// Step counter present only when CCI_MPF_PRIM_LFSR_STEP_COUNT_EN is defined.
module cci_mpf_prim_lfsr_lane #(
   parameter int               WIDTH        = 12,
   parameter int               STEPS_PER_EN = 1,
   parameter logic [WIDTH-1:0] MASK         = WIDTH'(12'h029),
   parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(12'hA6B)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             period_done,
   output logic             lockup_err,
   output logic [31:0]      step_count
);
   import cci_mpf_prim_lfsr_pkg::*;

   logic [WIDTH-1:0] value_q, value_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic             period_q, period_d;
   logic             lockup_q, lockup_d;
   logic [WIDTH-1:0] step_value;
   logic             step_hit;

   // Unrolled multi-step; any intermediate state matching the seed closes a period.
   always_comb begin
      step_value = value_q;
      step_hit   = 1'b0;
      for (int k = 0; k < STEPS_PER_EN; k++) begin
         step_value = WIDTH'(lfsr_step(lfsr_word_t'(step_value), lfsr_word_t'(MASK), WIDTH));
         if (step_value == seed_q) begin
            step_hit = 1'b1;
         end
      end
   end

   always_comb begin
      value_d  = value_q;
      seed_d   = seed_q;
      period_d = 1'b0;
      lockup_d = lockup_q;
      if (load_en) begin
         if (load_value == '0) begin
            value_d  = DEFAULT_SEED;
            seed_d   = DEFAULT_SEED;
            lockup_d = 1'b1;
         end else begin
            value_d = load_value;
            seed_d  = load_value;
         end
      end else if (en) begin
         value_d  = step_value;
         period_d = step_hit;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_q  <= DEFAULT_SEED;
         seed_q   <= DEFAULT_SEED;
         period_q <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         value_q  <= value_d;
         seed_q   <= seed_d;
         period_q <= period_d;
         lockup_q <= lockup_d;
      end
   end

   assign value       = value_q;
   assign period_done = period_q;
   assign lockup_err  = lockup_q;

`ifdef CCI_MPF_PRIM_LFSR_STEP_COUNT_EN
   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_en) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 32'(STEPS_PER_EN);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign step_count = count_q;
`else
   assign step_count = '0;
`endif

endmodule

// File: rtl/cci_mpf_prim_lfsr_multi.sv
// Bank of NUM_CHANNELS independent Galois LFSR lanes with per-lane seeds.
// Define CCI_MPF_PRIM_LFSR_STEP_COUNT_EN to build the per-lane step counters.
module cci_mpf_prim_lfsr_multi #(
   parameter int               WIDTH         = 12,
   parameter int               NUM_CHANNELS  = 1,
   parameter int               STEPS_PER_EN  = 1,
   parameter logic [WIDTH-1:0] TAPS          = '0,
   parameter logic [WIDTH-1:0] INITIAL_VALUE = WIDTH'(12'hA6B)
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [NUM_CHANNELS-1:0]             en,
   input  logic [NUM_CHANNELS-1:0]             load_en,
   input  logic [NUM_CHANNELS-1:0][WIDTH-1:0]  load_value,
   output logic [NUM_CHANNELS-1:0][WIDTH-1:0]  value,
   output logic [NUM_CHANNELS-1:0]             period_done,
   output logic [NUM_CHANNELS-1:0]             lockup_err,
   output logic [NUM_CHANNELS-1:0][31:0]       step_count
);
   import cci_mpf_prim_lfsr_pkg::*;

   localparam logic [WIDTH-1:0] TOP_BIT    = WIDTH'(1) << (WIDTH - 1);
   localparam logic [WIDTH-1:0] TABLE_TAPS = WIDTH'(lfsr_taps(WIDTH));
   // The MSB is fed by the rotate itself, so it never appears in the mask.
   localparam logic [WIDTH-1:0] MASK       = ((TAPS != '0) ? TAPS : TABLE_TAPS) & ~TOP_BIT;

   if (WIDTH < 2 || WIDTH > LFSR_MAX_WIDTH) begin : g_err_width
      $error("cci_mpf_prim_lfsr_multi: WIDTH %0d unsupported", WIDTH);
   end
   if (TAPS == '0 && TABLE_TAPS == '0) begin : g_err_taps
      $error("cci_mpf_prim_lfsr_multi: no tap table entry for WIDTH %0d", WIDTH);
   end
   if (INITIAL_VALUE == '0) begin : g_err_seed
      $error("cci_mpf_prim_lfsr_multi: INITIAL_VALUE must be nonzero");
   end
   if (STEPS_PER_EN < 1 || STEPS_PER_EN > 4) begin : g_err_steps
      $error("cci_mpf_prim_lfsr_multi: STEPS_PER_EN %0d outside 1..4", STEPS_PER_EN);
   end
   if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_err_chan
      $error("cci_mpf_prim_lfsr_multi: NUM_CHANNELS %0d outside 1..16", NUM_CHANNELS);
   end

   for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
      // Rotating the base seed per lane decorrelates lanes that share a reset.
      localparam logic [WIDTH-1:0] LANE_SEED =
         WIDTH'(lfsr_rotl(lfsr_word_t'(INITIAL_VALUE), gi % WIDTH, WIDTH));

      cci_mpf_prim_lfsr_lane #(
         .WIDTH        (WIDTH),
         .STEPS_PER_EN (STEPS_PER_EN),
         .MASK         (MASK),
         .DEFAULT_SEED (LANE_SEED)
      ) u_lane (
         .clk         (clk),
         .reset_n     (reset_n),
         .en          (en[gi]),
         .load_en     (load_en[gi]),
         .load_value  (load_value[gi]),
         .value       (value[gi]),
         .period_done (period_done[gi]),
         .lockup_err  (lockup_err[gi]),
         .step_count  (step_count[gi])
      );
   end

endmodule

// File: tb/tb_cci_mpf_prim_lfsr_multi.sv
// Bench for cci_mpf_prim_lfsr_multi: four configurations checked every cycle against
// an arithmetic reference model, plus directed checks with hand-derived constants.
module tb_cci_mpf_prim_lfsr_multi;

`ifdef CCI_MPF_PRIM_LFSR_STEP_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // A: W12 x2 lanes, 1 step   B: W12 x1, 2 steps   C: W4 x1, 1 step   D: W4 x3, 3 steps
   logic [1:0]        a_en, a_ld, a_pd, a_lk;
   logic [1:0][11:0]  a_lv, a_val;
   logic [1:0][31:0]  a_cnt;
   logic [0:0]        b_en, b_ld, b_pd, b_lk;
   logic [0:0][11:0]  b_lv, b_val;
   logic [0:0][31:0]  b_cnt;
   logic [0:0]        c_en, c_ld, c_pd, c_lk;
   logic [0:0][3:0]   c_lv, c_val;
   logic [0:0][31:0]  c_cnt;
   logic [2:0]        d_en, d_ld, d_pd, d_lk;
   logic [2:0][3:0]   d_lv, d_val;
   logic [2:0][31:0]  d_cnt;

   cci_mpf_prim_lfsr_multi #(.WIDTH(12), .NUM_CHANNELS(2), .STEPS_PER_EN(1),
                             .INITIAL_VALUE(12'hA6B)) dut_a (
      .clk(clk), .reset_n(rst_n), .en(a_en), .load_en(a_ld), .load_value(a_lv),
      .value(a_val), .period_done(a_pd), .lockup_err(a_lk), .step_count(a_cnt));
   cci_mpf_prim_lfsr_multi #(.WIDTH(12), .NUM_CHANNELS(1), .STEPS_PER_EN(2),
                             .INITIAL_VALUE(12'hA6B)) dut_b (
      .clk(clk), .reset_n(rst_n), .en(b_en), .load_en(b_ld), .load_value(b_lv),
      .value(b_val), .period_done(b_pd), .lockup_err(b_lk), .step_count(b_cnt));
   cci_mpf_prim_lfsr_multi #(.WIDTH(4), .NUM_CHANNELS(1), .STEPS_PER_EN(1),
                             .INITIAL_VALUE(4'h9)) dut_c (
      .clk(clk), .reset_n(rst_n), .en(c_en), .load_en(c_ld), .load_value(c_lv),
      .value(c_val), .period_done(c_pd), .lockup_err(c_lk), .step_count(c_cnt));
   cci_mpf_prim_lfsr_multi #(.WIDTH(4), .NUM_CHANNELS(3), .STEPS_PER_EN(3),
                             .INITIAL_VALUE(4'h5)) dut_d (
      .clk(clk), .reset_n(rst_n), .en(d_en), .load_en(d_ld), .load_value(d_lv),
      .value(d_val), .period_done(d_pd), .lockup_err(d_lk), .step_count(d_cnt));

   int          iw[4]   = '{12, 12, 4, 4};
   int          ist[4]  = '{1, 2, 1, 3};
   int          inch[4] = '{2, 1, 1, 3};
   logic [31:0] iinit[4] = '{32'hA6B, 32'hA6B, 32'h9, 32'h5};

   // Reference model state per [instance][lane]
   logic [31:0] mv[4][4], ms[4][4], mc[4][4];
   bit          mp[4][4], ml[4][4];

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_mask(input int w);
      case (w)
         4:       return 32'h1;
         12:      return 32'h029;
         default: return 32'h57;
      endcase
   endfunction

   function automatic logic [31:0] ref_step(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = v / 2 + (v % 2) * (32'd1 << (w - 1));
      if (v % 2 == 1) r = r ^ ref_mask(w);
      return r;
   endfunction

   function automatic logic [31:0] def_seed(input int i, input int c);
      logic [31:0] v;
      v = iinit[i];
      for (int k = 0; k < c % iw[i]; k++)
         v = (v * 2) % (32'd1 << iw[i]) + v / (32'd1 << (iw[i] - 1));
      return v;
   endfunction

   function automatic bit get_en(input int i, input int c);
      case (i)
         0: return a_en[c];
         1: return b_en[0];
         2: return c_en[0];
         default: return d_en[c];
      endcase
   endfunction

   function automatic bit get_ld(input int i, input int c);
      case (i)
         0: return a_ld[c];
         1: return b_ld[0];
         2: return c_ld[0];
         default: return d_ld[c];
      endcase
   endfunction

   function automatic logic [31:0] get_lv(input int i, input int c);
      case (i)
         0: return 32'(a_lv[c]);
         1: return 32'(b_lv[0]);
         2: return 32'(c_lv[0]);
         default: return 32'(d_lv[c]);
      endcase
   endfunction

   function automatic logic [31:0] get_val(input int i, input int c);
      case (i)
         0: return 32'(a_val[c]);
         1: return 32'(b_val[0]);
         2: return 32'(c_val[0]);
         default: return 32'(d_val[c]);
      endcase
   endfunction

   function automatic logic [2:0] get_flags(input int i, input int c);
      case (i)
         0: return {1'b0, a_pd[c], a_lk[c]};
         1: return {1'b0, b_pd[0], b_lk[0]};
         2: return {1'b0, c_pd[0], c_lk[0]};
         default: return {1'b0, d_pd[c], d_lk[c]};
      endcase
   endfunction

   function automatic logic [31:0] get_cnt(input int i, input int c);
      case (i)
         0: return a_cnt[c];
         1: return b_cnt[0];
         2: return c_cnt[0];
         default: return d_cnt[c];
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++)
         for (int c = 0; c < 4; c++) begin
            mv[i][c] = def_seed(i, c);
            ms[i][c] = def_seed(i, c);
            mp[i][c] = 1'b0;
            ml[i][c] = 1'b0;
            mc[i][c] = '0;
         end
   endtask

   task automatic model_update();
      logic [31:0] lv;
      bit          hit;
      for (int i = 0; i < 4; i++)
         for (int c = 0; c < inch[i]; c++) begin
            if (get_ld(i, c)) begin
               lv = get_lv(i, c) % (32'd1 << iw[i]);
               mp[i][c] = 1'b0;
               mc[i][c] = '0;
               if (lv == 0) begin
                  mv[i][c] = def_seed(i, c);
                  ms[i][c] = def_seed(i, c);
                  ml[i][c] = 1'b1;
               end else begin
                  mv[i][c] = lv;
                  ms[i][c] = lv;
               end
            end else if (get_en(i, c)) begin
               hit = 1'b0;
               for (int k = 0; k < ist[i]; k++) begin
                  mv[i][c] = ref_step(mv[i][c], iw[i]);
                  if (mv[i][c] == ms[i][c]) hit = 1'b1;
               end
               mp[i][c] = hit;
               mc[i][c] = mc[i][c] + 32'(ist[i]);
            end else begin
               mp[i][c] = 1'b0;
            end
         end
   endtask

   task automatic compare_all();
      logic [2:0] f;
      for (int i = 0; i < 4; i++)
         for (int c = 0; c < inch[i]; c++) begin
            f = get_flags(i, c);
            check($sformatf("value[%0d][%0d]", i, c), get_val(i, c), mv[i][c]);
            check($sformatf("period_done[%0d][%0d]", i, c), 32'(f[1]), 32'(mp[i][c]));
            check($sformatf("lockup_err[%0d][%0d]", i, c), 32'(f[0]), 32'(ml[i][c]));
            check($sformatf("step_count[%0d][%0d]", i, c), get_cnt(i, c),
                  CNT_EN ? mc[i][c] : 32'd0);
         end
   endtask

   task automatic idle();
      a_en = '0; a_ld = '0; a_lv = '0;
      b_en = '0; b_ld = '0; b_lv = '0;
      c_en = '0; c_ld = '0; c_lv = '0;
      d_en = '0; d_ld = '0; d_lv = '0;
   endtask

   task automatic rand_inputs();
      a_en = 2'($urandom);
      b_en = 1'($urandom);
      c_en = 1'($urandom_range(0, 3) != 0);
      d_en = 3'($urandom);
      for (int c = 0; c < 2; c++) begin
         a_ld[c] = ($urandom_range(0, 9) == 0);
         a_lv[c] = ($urandom_range(0, 3) == 0) ? 12'h0 : 12'($urandom);
      end
      b_ld[0] = ($urandom_range(0, 9) == 0);
      b_lv[0] = ($urandom_range(0, 3) == 0) ? 12'h0 : 12'($urandom);
      c_ld[0] = ($urandom_range(0, 19) == 0);
      c_lv[0] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      for (int c = 0; c < 3; c++) begin
         d_ld[c] = ($urandom_range(0, 9) == 0);
         d_lv[c] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      end
   endtask

   task automatic cycle();
      $display("cyc %0d a:en=%b ld=%b lv=%h b:en=%b ld=%b c:en=%b ld=%b lv=%h d:en=%b ld=%b lv=%h",
               cyc, a_en, a_ld, a_lv, b_en, b_ld, c_en, c_ld, c_lv, d_en, d_ld, d_lv);
      cyc++;
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      compare_all();
      check("reset a0", 32'(a_val[0]), 32'hA6B);
      check("reset a1 rotl", 32'(a_val[1]), 32'h4D7);

      // First steps from reset, single and double stepping
      a_en = 2'b01; b_en = 1'b1;
      cycle();
      check("a0 step1", 32'(a_val[0]), 32'hD1C);
      check("b two steps", 32'(b_val[0]), 32'h68E);
      check("b step_count", b_cnt[0], CNT_EN ? 32'd2 : 32'd0);
      idle();
      a_en = 2'b01;
      cycle();
      check("a0 step2", 32'(a_val[0]), 32'h68E);
      idle();

      // Full 15-state period on the 4-bit lane
      c_ld = 1'b1; c_lv = 4'h1;
      cycle();
      check("c load no pulse", 32'(c_pd[0]), 32'd0);
      idle();
      for (int k = 0; k < 15; k++) begin
         c_en = 1'b1;
         cycle();
         if (k < 14) check($sformatf("c no early pulse %0d", k), 32'(c_pd[0]), 32'd0);
      end
      check("c period pulse", 32'(c_pd[0]), 32'd1);
      check("c back to seed", 32'(c_val[0]), 32'h1);
      idle();
      cycle();
      check("c pulse one cycle", 32'(c_pd[0]), 32'd0);

      // Zero-seed load falls back to the lane default and sets the sticky flag
      a_ld = 2'b10; a_lv[1] = 12'h000;
      cycle();
      check("a1 zero load value", 32'(a_val[1]), 32'h4D7);
      check("a1 lockup set", 32'(a_lk[1]), 32'd1);
      check("a0 lockup clear", 32'(a_lk[0]), 32'd0);
      a_lv[1] = 12'h555;
      cycle();
      check("a1 lockup sticky", 32'(a_lk[1]), 32'd1);
      check("a1 reload", 32'(a_val[1]), 32'h555);
      idle();

      // Load wins over enable
      a_ld = 2'b01; a_en = 2'b01; a_lv[0] = 12'h123;
      cycle();
      check("a0 load over en", 32'(a_val[0]), 32'h123);
      check("a0 count cleared", a_cnt[0], 32'd0);
      idle();

      for (int n = 0; n < 250; n++) begin
         rand_inputs();
         cycle();
      end

      // Asynchronous reset between clock edges
      rand_inputs();
      @(posedge clk);
      model_update();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("async reset a0", 32'(a_val[0]), 32'hA6B);
      check("async reset c", 32'(c_val[0]), 32'h9);
      check("async reset a1 lockup", 32'(a_lk[1]), 32'd0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      compare_all();

      for (int n = 0; n < 80; n++) begin
         rand_inputs();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
